// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Request and memory-side bus bundle for fetch_unit.
// Revision    : 1.0
// ============================================================================
interface fetch_unit_if;
    logic [15:0] program_counter;
    logic        fetch_request;
    logic [23:0] instruction_bus;
    logic        instruction_ready;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_ready;
    logic [7:0]  mem_data;

    // Requester / memory side
    modport master (
        output program_counter, fetch_request, mem_ready, mem_data,
        input  instruction_bus, instruction_ready, mem_address, mem_read
    );

    // Fetch unit side
    modport slave (
        input  program_counter, fetch_request, mem_ready, mem_data,
        output instruction_bus, instruction_ready, mem_address, mem_read
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetches a 24-bit big-endian instruction as three byte reads.
//               Optional next-instruction prefetch via FETCH_UNIT_PREFETCH_EN.
// Revision    : 1.0
// ============================================================================
module fetch_unit (
    input  wire logic   clk,
    input  wire logic   reset,
    fetch_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_FETCH2 = 3'd3,
`ifdef FETCH_UNIT_PREFETCH_EN
        S_DONE   = 3'd4,
        S_PRE0   = 3'd5,
        S_PRE1   = 3'd6,
        S_PRE2   = 3'd7
`else
        S_DONE   = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_base;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic [23:0] r_instr;
    logic        w_mem_read;
    logic [15:0] w_mem_addr;

`ifdef FETCH_UNIT_PREFETCH_EN
    logic [23:0] r_buf;
    logic        r_buf_valid;
    logic        r_pend;
    logic [15:0] w_tag;
    logic        w_hit_req;
    logic        w_miss_req;

    // The buffered instruction always starts right after the last one fetched.
    assign w_tag      = r_base + 16'd3;
    assign w_hit_req  = bus.fetch_request && (bus.program_counter == w_tag);
    assign w_miss_req = bus.fetch_request && !r_pend && (bus.program_counter != w_tag);
`endif

    always_comb begin
        w_next     = r_state;
        w_mem_read = 1'b0;
        w_mem_addr = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (bus.fetch_request) begin
`ifdef FETCH_UNIT_PREFETCH_EN
                    w_next = (r_buf_valid && w_hit_req) ? S_DONE : S_FETCH0;
`else
                    w_next = S_FETCH0;
`endif
                end
            end
            S_FETCH0: begin
                w_mem_read = 1'b1;
                w_mem_addr = r_base;
                if (bus.mem_ready) w_next = S_FETCH1;
            end
            S_FETCH1: begin
                w_mem_read = 1'b1;
                w_mem_addr = r_base + 16'd1;
                if (bus.mem_ready) w_next = S_FETCH2;
            end
            S_FETCH2: begin
                w_mem_read = 1'b1;
                w_mem_addr = r_base + 16'd2;
                if (bus.mem_ready) w_next = S_DONE;
            end
            S_DONE: begin
`ifdef FETCH_UNIT_PREFETCH_EN
                w_next = S_PRE0;
`else
                w_next = S_IDLE;
`endif
            end
`ifdef FETCH_UNIT_PREFETCH_EN
            S_PRE0: begin
                w_mem_read = 1'b1;
                w_mem_addr = w_tag;
                if (w_miss_req)         w_next = S_FETCH0;
                else if (bus.mem_ready) w_next = S_PRE1;
            end
            S_PRE1: begin
                w_mem_read = 1'b1;
                w_mem_addr = w_tag + 16'd1;
                if (w_miss_req)         w_next = S_FETCH0;
                else if (bus.mem_ready) w_next = S_PRE2;
            end
            S_PRE2: begin
                w_mem_read = 1'b1;
                w_mem_addr = w_tag + 16'd2;
                if (w_miss_req)         w_next = S_FETCH0;
                else if (bus.mem_ready) w_next = (r_pend || w_hit_req) ? S_DONE : S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_base  <= 16'h0000;
            r_byte0 <= 8'h00;
            r_byte1 <= 8'h00;
            r_instr <= 24'h000000;
`ifdef FETCH_UNIT_PREFETCH_EN
            r_buf       <= 24'h000000;
            r_buf_valid <= 1'b0;
            r_pend      <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.fetch_request) begin
                        r_base <= bus.program_counter;
`ifdef FETCH_UNIT_PREFETCH_EN
                        // Hit or miss, the buffer is consumed or stale now.
                        r_buf_valid <= 1'b0;
                        if (r_buf_valid && w_hit_req) r_instr <= r_buf;
`endif
                    end
                end
                S_FETCH0: if (bus.mem_ready) r_byte0 <= bus.mem_data;
                S_FETCH1: if (bus.mem_ready) r_byte1 <= bus.mem_data;
                S_FETCH2: if (bus.mem_ready) r_instr <= {r_byte0, r_byte1, bus.mem_data};
`ifdef FETCH_UNIT_PREFETCH_EN
                S_PRE0, S_PRE1, S_PRE2: begin
                    if (w_miss_req) begin
                        r_base      <= bus.program_counter;
                        r_buf_valid <= 1'b0;
                        r_pend      <= 1'b0;
                    end else begin
                        if (w_hit_req) r_pend <= 1'b1;
                        if (bus.mem_ready) begin
                            if (r_state == S_PRE0) r_byte0 <= bus.mem_data;
                            if (r_state == S_PRE1) r_byte1 <= bus.mem_data;
                            if (r_state == S_PRE2) begin
                                r_pend <= 1'b0;
                                if (r_pend || w_hit_req) begin
                                    r_instr <= {r_byte0, r_byte1, bus.mem_data};
                                    r_base  <= w_tag;
                                end else begin
                                    r_buf       <= {r_byte0, r_byte1, bus.mem_data};
                                    r_buf_valid <= 1'b1;
                                end
                            end
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.instruction_bus   = r_instr;
    assign bus.instruction_ready = (r_state == S_DONE);
    assign bus.mem_read          = w_mem_read;
    assign bus.mem_address       = w_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fetch_unit_if fif ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0010: return 8'hAA;
            16'h0011: return 8'hBB;
            16'h0012: return 8'hCC;
            16'h0013: return 8'hDD;
            16'h0014: return 8'hEE;
            16'h0015: return 8'hF0;
            16'hFFFE: return 8'h11;
            16'hFFFF: return 8'h22;
            16'h0000: return 8'h33;
            16'h0100: return 8'h12;
            16'h0101: return 8'h34;
            16'h0102: return 8'h56;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    assign fif.mem_data = mem_byte(fif.mem_address);

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        fif.program_counter = 16'h0000;
        fif.fetch_request   = 1'b0;
        fif.mem_ready       = 1'b1;
        repeat (3) step();
        check("rst_ready", fif.instruction_ready, 24'd0);
        check("rst_read",  fif.mem_read, 24'd0);
        check("rst_addr",  fif.mem_address, 24'h0000);
        check("rst_bus",   fif.instruction_bus, 24'h000000);
        reset = 1'b0;
        step();

        // Basic fetch, latency 4
        fif.program_counter = 16'h0010;
        fif.fetch_request   = 1'b1;
        step();
        check("t1_f0_read",  fif.mem_read, 24'd1);
        check("t1_f0_addr",  fif.mem_address, 24'h0010);
        check("t1_f0_rdy",   fif.instruction_ready, 24'd0);
        step();
        check("t1_f1_addr",  fif.mem_address, 24'h0011);
        check("t1_f1_rdy",   fif.instruction_ready, 24'd0);
        step();
        check("t1_f2_addr",  fif.mem_address, 24'h0012);
        check("t1_f2_rdy",   fif.instruction_ready, 24'd0);
        step();
        check("t1_done_rdy",  fif.instruction_ready, 24'd1);
        check("t1_done_bus",  fif.instruction_bus, 24'hAABBCC);
        check("t1_done_read", fif.mem_read, 24'd0);
        fif.fetch_request = 1'b0;
        step();
        check("t1_after_rdy", fif.instruction_ready, 24'd0);
        check("t1_after_bus", fif.instruction_bus, 24'hAABBCC);
`ifndef FETCH_UNIT_PREFETCH_EN
        check("t1_after_read", fif.mem_read, 24'd0);
`endif

        // Address wrap-around
        fif.program_counter = 16'hFFFE;
        fif.fetch_request   = 1'b1;
        step();
        check("t2_addr0", fif.mem_address, 24'hFFFE);
        step();
        check("t2_addr1", fif.mem_address, 24'hFFFF);
        step();
        check("t2_addr2", fif.mem_address, 24'h0000);
        step();
        check("t2_rdy", fif.instruction_ready, 24'd1);
        check("t2_bus", fif.instruction_bus, 24'h112233);
        fif.fetch_request = 1'b0;
        step();

        // Memory stall in FETCH1 for five cycles
        fif.program_counter = 16'h0040;
        fif.fetch_request   = 1'b1;
        step();
        check("t3_addr0", fif.mem_address, 24'h0040);
        step();
        check("t3_addr1", fif.mem_address, 24'h0041);
        fif.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_addr", fif.mem_address, 24'h0041);
            check("t3_hold_read", fif.mem_read, 24'd1);
            check("t3_hold_rdy",  fif.instruction_ready, 24'd0);
        end
        fif.mem_ready = 1'b1;
        step();
        check("t3_addr2", fif.mem_address, 24'h0042);
        check("t3_rdy_early", fif.instruction_ready, 24'd0);
        step();
        check("t3_rdy", fif.instruction_ready, 24'd1);
        check("t3_bus", fif.instruction_bus, 24'h1A1B18);
        fif.fetch_request = 1'b0;
        step();

        // Another address pattern
        fif.program_counter = 16'h1234;
        fif.fetch_request   = 1'b1;
        step();
        check("t4_addr0", fif.mem_address, 24'h1234);
        step();
        step();
        check("t4_addr2", fif.mem_address, 24'h1236);
        step();
        check("t4_rdy", fif.instruction_ready, 24'd1);
        check("t4_bus", fif.instruction_bus, 24'h7C7D7E);
        fif.fetch_request = 1'b0;
        step();

        // Reset mid-fetch, with request and mem_ready both still high
        fif.program_counter = 16'h0020;
        fif.fetch_request   = 1'b1;
        step();
        step();
        check("t5_f1_addr", fif.mem_address, 24'h0021);
        reset = 1'b1;
        step();
        check("t5_read", fif.mem_read, 24'd0);
        check("t5_rdy",  fif.instruction_ready, 24'd0);
        check("t5_bus",  fif.instruction_bus, 24'h000000);
        check("t5_addr", fif.mem_address, 24'h0000);
        reset = 1'b0;
        fif.fetch_request = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_no_rdy", fif.instruction_ready, 24'd0);
        end

`ifdef FETCH_UNIT_PREFETCH_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        fif.program_counter = 16'h0010;
        fif.fetch_request   = 1'b1;
        repeat (4) step();
        check("p1_rdy", fif.instruction_ready, 24'd1);
        check("p1_bus", fif.instruction_bus, 24'hAABBCC);
        fif.fetch_request = 1'b0;
        step();
        check("p1_pre0_addr", fif.mem_address, 24'h0013);
        check("p1_pre0_read", fif.mem_read, 24'd1);
        step();
        check("p1_pre1_addr", fif.mem_address, 24'h0014);
        step();
        check("p1_pre2_addr", fif.mem_address, 24'h0015);
        step();
        check("p1_idle_read", fif.mem_read, 24'd0);
        fif.program_counter = 16'h0013;
        fif.fetch_request   = 1'b1;
        step();
        check("p2_hit_rdy", fif.instruction_ready, 24'd1);
        check("p2_hit_bus", fif.instruction_bus, 24'hDDEEF0);
        fif.fetch_request = 1'b0;
        step();
        check("p2_pre0_addr", fif.mem_address, 24'h0016);
        step();
        check("p3_pre1_addr", fif.mem_address, 24'h0017);
        fif.program_counter = 16'h0100;
        fif.fetch_request   = 1'b1;
        step();
        check("p3_f0_addr", fif.mem_address, 24'h0100);
        check("p3_f0_read", fif.mem_read, 24'd1);
        repeat (3) step();
        check("p3_rdy", fif.instruction_ready, 24'd1);
        check("p3_bus", fif.instruction_bus, 24'h123456);
        fif.fetch_request = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
